adpcm_capture_ctrl: RTL
=======================

// Module: adpcm_capture_ctrl
// PURPOSE
//  Sequencer for the CIC/ADPCM compressor: generates the PDM mic clock and the slow (PCM-rate) clock,
//  gates the compressor's block_enable, and discards CIC warm-up codes. Packs the 4-bit ADPCM codes
//  into bytes and buffers them in a small FIFO with a valid/ready output. Sits between the top-level
//  pins and the compressor; the host drains bytes at its own pace.
// PARAMETERS
//  PDM_DIV     8   clk cycles per PDM bit clock period (even, >=4)
//  DECIM       64  PDM periods per slow_clk period (= PCM/ADPCM sample); even, >=2
//  WARMUP      4   ADPCM codes discarded after start (CIC settle)
//  FIFO_DEPTH  4   byte FIFO depth (power of 2)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous, active-high reset
//  start          in   1  1-cycle pulse: begin capture (honoured only in IDLE)
//  stop           in   1  1-cycle pulse: end capture (honoured only in WARMUP/RUN)
//  pdm_clk_o      out  1  clock to PDM microphone
//  slow_clk_o     out  1  slow clock to compressor
//  block_enable_o out  1  compressor enable
//  enc_valid_i    in   1  compressor outValid (level, slow-clock timed)
//  enc_pcm_i      in   4  compressor encPcm
//  byte_data      out  8  packed output byte
//  byte_valid     out  1  byte_data valid
//  byte_ready     in   1  host accepts byte when byte_valid & byte_ready
//  busy           out  1  state != IDLE
//  overflow       out  1  sticky: a byte was dropped on full FIFO; cleared by accepted start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, FIFO empty, nibble latch empty, overflow 0.
//  FSM: IDLE -start-> WARMUP -WARMUP codes seen-> RUN -stop-> DRAIN -FIFO empty-> IDLE.
//   WARMUP -stop-> DRAIN. WARMUP=0: IDLE -start-> RUN directly. start/stop outside their states ignored.
//  Dividers run only in WARMUP/RUN; in IDLE/DRAIN held at 0, pdm_clk_o=slow_clk_o=0.
//   pdm_cnt 0..PDM_DIV-1; pdm_clk_o=1 for pdm_cnt<PDM_DIV/2.
//   slow_cnt counts completed PDM periods 0..DECIM-1 (advances when pdm_cnt wraps);
//   slow_clk_o=1 for slow_cnt<DECIM/2. slow_clk_o period = PDM_DIV*DECIM clk cycles.
//  block_enable_o = 1 exactly in WARMUP and RUN (registered; rises cycle after start).
//  Code accept: registered enc_valid_i; a code is taken on its 0->1 edge, enc_pcm_i sampled same cycle.
//   Edges while in IDLE/DRAIN ignored. In WARMUP, edges only decrement the warm-up count.
//  Packing (RUN): first code -> byte[7:4] (latch half=1); second -> byte[3:0], push byte, half=0.
//  DRAIN entry with half=1: push {hi,4'h0} in the entry cycle, half=0.
//  FIFO push when full and no pop same cycle: byte dropped, overflow<=1. Push+pop when full: both occur.
//  byte_valid = FIFO non-empty; byte_data = head; first byte visible cycle after its push;
//   byte_data stable while byte_valid & !byte_ready. Pop on empty impossible (valid=0).
//  DRAIN -> IDLE in the cycle after count reaches 0; host may keep draining bytes during DRAIN.
//  rst mid-operation: immediate return to reset state; buffered bytes lost.
//  Accepted start clears overflow and half; FIFO contents are not flushed (always empty in IDLE).
// STRUCTURE
//  Package adpcm_ctrl_pkg: state enum (IDLE,WARMUP,RUN,DRAIN), NIB_W=4, BYTE_W=8 constants.
//  Sub-module sync_byte_fifo (DEPTH param, push/pop/full/empty/head, simultaneous push+pop).
//  Top: FSM, two divider counters, warm-up counter, edge detector, nibble latch.
// TESTING (PDM_DIV=8, DECIM=64, WARMUP=4, FIFO_DEPTH=4 unless stated)
//  Reset then start: pdm_clk_o period 8 clk (4 high), slow_clk_o period 512 clk; block_enable_o=1 next cycle.
//  Feed codes 1,2,3,4 (warm-up) then A,5 -> single byte 8'hA5 with byte_valid; warm-up codes never appear.
//  Codes A,5,C,3 with byte_ready=1 -> bytes 8'hA5 then 8'hC3, in order, each once.
//  byte_ready=0, 10 codes after warm-up -> 4 bytes held, 5th dropped, overflow=1; start after IDLE clears it.
//  stop after one code 7 in RUN -> byte 8'h70 pushed, block_enable_o=0, busy drops after FIFO drained.
//  rst asserted in RUN with 2 bytes buffered -> next cycle byte_valid=0, busy=0, all clocks 0.

Source files
------------

// File: rtl/adpcm_ctrl_pkg.sv
// Shared types and widths for the ADPCM capture sequencer.
// No logic; no latency.
// No flow control.
package adpcm_ctrl_pkg;
    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;
endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous FIFO with combinational head and simultaneous push/pop.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module sync_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_en;
    logic         rd_en;

    // Extra pointer bit separates full from empty when the indices coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/adpcm_capture_ctrl.sv
// Capture sequencer: mic/slow clock dividers, warm-up discard, nibble packing, byte FIFO.
// Latency: a completed byte is visible on byte_data the cycle after its second nibble edge.
// Backpressure: byte_ready low holds the FIFO head; a byte arriving on a full FIFO is dropped (sticky overflow).
module adpcm_capture_ctrl
    import adpcm_ctrl_pkg::*;
#(
    parameter int PDM_DIV    = 8,
    parameter int DECIM      = 64,
    parameter int WARMUP     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              pdm_clk_o,
    output logic              slow_clk_o,
    output logic              block_enable_o,
    input  logic              enc_valid_i,
    input  logic [NIB_W-1:0]  enc_pcm_i,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              overflow
);
    localparam int PW = $clog2(PDM_DIV);
    localparam int SW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [PW-1:0]      pdm_cnt;
    logic [PW-1:0]      pdm_nxt;
    logic [SW-1:0]      slow_cnt;
    logic [SW-1:0]      slow_nxt;
    logic [WW-1:0]      warm_cnt;
    logic               enc_valid_q;
    logic               code_edge;
    logic               half;
    logic [NIB_W-1:0]   hi_nib;
    logic               active;
    logic               active_nxt;
    logic               push;
    logic [BYTE_W-1:0]  push_dat;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [BYTE_W-1:0]  fifo_head;

    assign code_edge  = enc_valid_i && !enc_valid_q;
    assign active     = (state == ST_WARMUP) || (state == ST_RUN);
    assign active_nxt = (state_nxt == ST_WARMUP) || (state_nxt == ST_RUN);
    assign pop        = byte_ready && !fifo_empty;
    assign byte_valid = !fifo_empty;
    assign byte_data  = fifo_empty ? '0 : fifo_head;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (stop) begin
                    state_nxt = ST_DRAIN;
                end else if (code_edge && warm_cnt == WW'(1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_DRAIN;
                end
            end
            default: begin
                // Leave only once the trailing half byte is out and the host has emptied the FIFO.
                if (!half && fifo_empty) begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        pdm_nxt  = '0;
        slow_nxt = '0;
        if (active && active_nxt) begin
            if (pdm_cnt == PW'(PDM_DIV - 1)) begin
                pdm_nxt  = '0;
                slow_nxt = (slow_cnt == SW'(DECIM - 1)) ? '0 : slow_cnt + SW'(1);
            end else begin
                pdm_nxt  = pdm_cnt + PW'(1);
                slow_nxt = slow_cnt;
            end
        end
    end

    always_comb begin
        push     = 1'b0;
        push_dat = {hi_nib, enc_pcm_i};
        if (state == ST_RUN && !stop && code_edge && half) begin
            push = 1'b1;
        end else if (state == ST_DRAIN && half) begin
            push     = 1'b1;
            push_dat = {hi_nib, NIB_W'(0)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            pdm_cnt        <= '0;
            slow_cnt       <= '0;
            pdm_clk_o      <= 1'b0;
            slow_clk_o     <= 1'b0;
            block_enable_o <= 1'b0;
            enc_valid_q    <= 1'b0;
            warm_cnt       <= '0;
            half           <= 1'b0;
            hi_nib         <= '0;
            overflow       <= 1'b0;
        end else begin
            state          <= state_nxt;
            pdm_cnt        <= pdm_nxt;
            slow_cnt       <= slow_nxt;
            pdm_clk_o      <= active_nxt && (pdm_nxt < PW'(PDM_DIV / 2));
            slow_clk_o     <= active_nxt && (slow_nxt < SW'(DECIM / 2));
            block_enable_o <= active_nxt;
            enc_valid_q    <= enc_valid_i;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        warm_cnt <= WW'(WARMUP);
                        overflow <= 1'b0;
                        half     <= 1'b0;
                    end
                end
                ST_WARMUP: begin
                    if (!stop && code_edge && warm_cnt != '0) begin
                        warm_cnt <= warm_cnt - WW'(1);
                    end
                end
                ST_RUN: begin
                    if (!stop && code_edge) begin
                        if (half) begin
                            half <= 1'b0;
                        end else begin
                            hi_nib <= enc_pcm_i;
                            half   <= 1'b1;
                        end
                    end
                end
                default: begin
                    half <= 1'b0;
                end
            endcase
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );
endmodule
